tag_compare_assoc: RTL

//  Set-associative tag comparator for the DRAM cache, placed between the request FIFO and the

---
 rtl/tag_compare_assoc.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tag_compare_assoc.sv
// tag_compare_assoc: set-associative tag comparator for the DRAM cache.
// It accepts one request, waits for the tag-store beat that matches the request ID,
// compares all ways in parallel, and then presents the result on one of four
// valid/ready channels (RHIT, RMISS, WHIT, WMISS). Only one request is in flight.
// Optional feature: define TAG_CMP_STATS_EN to add per-channel 32-bit saturating
// handshake counters and a synchronous clear input (stat_clr_i).
module tag_compare_assoc #(
  parameter  int ADDR_W   = 64,
  parameter  int OFFSET_W = 6,
  parameter  int INDEX_W  = 16,
  parameter  int WAYS     = 2,
  parameter  int ID_W     = 4,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int ENT_W    = TAG_W + 2,
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [ID_W-1:0]       req_id_i,
  input  logic [ID_W-1:0]       rid_i,
  input  logic [WAYS*ENT_W-1:0] rdata_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [3:0]            out_valid_o,
  input  logic [3:0]            out_ready_i,
  output logic [ADDR_W-1:0]     out_addr_o,
  output logic [WAY_W-1:0]      out_way_o,
  output logic                  out_dirty_o,
`ifdef TAG_CMP_STATS_EN
  input  logic                  stat_clr_i,
  output logic [31:0]           stat_rhit_o,
  output logic [31:0]           stat_rmiss_o,
  output logic [31:0]           stat_whit_o,
  output logic [31:0]           stat_wmiss_o,
`endif
  output logic                  id_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT_TAG, CMP, SEND} state_t;

  state_t                  state_reg, state_next;
  logic                    write_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [ID_W-1:0]         id_reg;
  logic [WAYS*ENT_W-1:0]   tags_reg;
  logic [1:0]              cls_reg;
  logic [WAY_W-1:0]        way_reg;
  logic                    dirty_reg;
  logic [WAY_W-1:0]        ptr_reg;

  logic [TAG_W-1:0]        req_tag;
  logic [WAYS-1:0]         way_valid, way_dirty, way_hit;
  logic                    hit_any, all_valid, vict_dirty, beat_ok;
  logic [WAY_W-1:0]        hit_way, inv_way, vict_way;

  assign req_tag = addr_reg[ADDR_W-1 -: TAG_W];
  assign beat_ok = rvalid_i && (rid_i == id_reg);

  // Unpack each way entry {valid, dirty, tag} and compare against the request tag
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_valid[gi] = tags_reg[gi*ENT_W + ENT_W - 1];
      assign way_dirty[gi] = tags_reg[gi*ENT_W + ENT_W - 2];
      assign way_hit[gi]   = way_valid[gi] && (tags_reg[gi*ENT_W +: TAG_W] == req_tag);
    end
  endgenerate

  // Priority pick: lowest hit way, else lowest invalid way, else round-robin victim
  always_comb begin
    hit_any    = |way_hit;
    all_valid  = &way_valid;
    hit_way    = '0;
    inv_way    = '0;
    vict_dirty = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_hit[i])    hit_way = WAY_W'(i);
      if (!way_valid[i]) inv_way = WAY_W'(i);
    end
    vict_way = all_valid ? ptr_reg : inv_way;
    for (int i = 0; i < WAYS; i++) begin
      if (WAY_W'(i) == vict_way) vict_dirty = way_valid[i] & way_dirty[i];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next  = state_reg;
    req_ready_o = 1'b0;
    rready_o    = 1'b0;
    id_err_o    = 1'b0;
    out_valid_o = 4'b0000;
    case (state_reg)
      IDLE: begin
        req_ready_o = !rst;
        if (req_valid_i) state_next = WAIT_TAG;
      end
      WAIT_TAG: begin
        rready_o = 1'b1;
        id_err_o = rvalid_i && !beat_ok;
        if (beat_ok) state_next = CMP;
      end
      CMP: state_next = SEND;
      SEND: begin
        out_valid_o = 4'b0001 << cls_reg;
        if (out_ready_i[cls_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, tag beat capture, and compare result / victim pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg <= 1'b0;
      addr_reg  <= '0;
      id_reg    <= '0;
      tags_reg  <= '0;
      cls_reg   <= 2'd0;
      way_reg   <= '0;
      dirty_reg <= 1'b0;
      ptr_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            write_reg <= req_write_i;
            addr_reg  <= req_addr_i;
            id_reg    <= req_id_i;
          end
        end
        WAIT_TAG: begin
          if (beat_ok) tags_reg <= rdata_i;
        end
        CMP: begin
          cls_reg   <= {write_reg, !hit_any};
          way_reg   <= hit_any ? hit_way : vict_way;
          dirty_reg <= hit_any ? 1'b0 : vict_dirty;
          if (!hit_any && all_valid && (WAYS > 1)) begin
            ptr_reg <= (ptr_reg == WAY_W'(WAYS - 1)) ? '0 : ptr_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_addr_o  = addr_reg;
  assign out_way_o   = way_reg;
  assign out_dirty_o = dirty_reg;

`ifdef TAG_CMP_STATS_EN
  logic [31:0] stat_cnt_reg [4];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_stat
      // Saturating handshake counter; clear takes priority over a same-cycle increment
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stat_cnt_reg[gi] <= '0;
        end else if (stat_clr_i) begin
          stat_cnt_reg[gi] <= '0;
        end else if (out_valid_o[gi] && out_ready_i[gi] && (stat_cnt_reg[gi] != '1)) begin
          stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign stat_rhit_o  = stat_cnt_reg[0];
  assign stat_rmiss_o = stat_cnt_reg[1];
  assign stat_whit_o  = stat_cnt_reg[2];
  assign stat_wmiss_o = stat_cnt_reg[3];
`endif

endmodule
